aib_avmm_cfg_arbiter: RTL
=========================

AIB_AVMM_CFG_ARBITER -- requirements
Module: aib_avmm_cfg_arbiter

Interface
REQ-001 Parameter ADDR_W, default 17, AVMM address width at the AIB PHY config port.
REQ-002 Parameter DATA_W, default 32, AVMM data width; byteenable width is DATA_W/8.
REQ-003 Parameter TIMEOUT_CYC, default 255, maximum cycles a granted transaction may stay outstanding.
REQ-004 Clock and reset: one clock, avmm_clk; reset avmm_rst_n is asynchronous and active-low.
REQ-005 avmm_clk  input  1  single clock for all logic.
REQ-006 avmm_rst_n  input  1  asynchronous active-low reset.
REQ-007 rK_address/rK_read/rK_write/rK_writedata/rK_byteenable  input  ADDR_W/1/1/DATA_W/DATA_W/8  AVMM request from requester K (K=0 calibration sequencer, K=1 host/debug).
REQ-008 rK_readdata/rK_readdatavalid/rK_waitrequest  output  DATA_W/1/1  AVMM response to requester K.
REQ-009 m_address/m_read/m_write/m_writedata/m_byteenable  output  ADDR_W/1/1/DATA_W/DATA_W/8  AVMM command to the PHY config port.
REQ-010 m_readdata/m_readdatavalid/m_waitrequest  input  DATA_W/1/1  AVMM response from the PHY.
REQ-011 clr_err  input  1  synchronous clear of timeout_err.
REQ-012 grant  output  2  one-hot owner of the PHY port, 0 when idle.
REQ-013 timeout_err  output  1  sticky flag, a transaction was aborted by timeout.

Function
REQ-014 FSM states IDLE, CMD, RDWAIT; grant and the state are registered.
REQ-015 IDLE: a requester requests when rK_read|rK_write; on any request the FSM moves to CMD and sets grant the next cycle.
REQ-016 Arbitration is round-robin: single request wins; on simultaneous requests the requester not granted last wins; last-grant pointer resets to 1 so r0 wins the first tie.
REQ-017 CMD: m_* equal the granted requester's signals combinationally; rK_waitrequest of the granted requester equals m_waitrequest.
REQ-018 Non-granted requesters, and all requesters in IDLE, see rK_waitrequest=1 whenever they assert read or write, and rK_readdatavalid=0.
REQ-019 m_read and m_write are 0 in IDLE and RDWAIT; both are 0 in reset.
REQ-020 If a requester asserts read and write together, write is forwarded and read is ignored.
REQ-021 CMD with write and m_waitrequest=0: transfer done, FSM goes to IDLE next cycle.
REQ-022 CMD with read and m_waitrequest=0: FSM goes to RDWAIT; if m_readdatavalid=1 in that same cycle it is forwarded and the FSM goes to IDLE instead.
REQ-023 RDWAIT: m_readdata/m_readdatavalid are routed to the granted requester only; the first m_readdatavalid=1 returns the FSM to IDLE.
REQ-024 m_readdatavalid outside CMD/RDWAIT is dropped.
REQ-025 A timeout counter clears on entry to CMD and increments each cycle in CMD or RDWAIT.
REQ-026 When the counter reaches TIMEOUT_CYC, the FSM aborts to IDLE: the granted requester gets waitrequest=0 for that cycle, plus readdatavalid=1 with readdata=ERR_RDATA if a read; m_read/m_write are forced to 0 and timeout_err is set.
REQ-027 timeout_err stays set until clr_err=1; a new timeout and clr_err in the same cycle leave it set.
REQ-028 Minimum turnaround: the cycle after return to IDLE is spent in IDLE, so back-to-back transfers take at least 2 cycles plus PHY latency.

Reset
REQ-029 Reset forces state=IDLE, grant=0, last-grant=1, counter=0, timeout_err=0.
REQ-030 Reset asserted mid-transaction abandons it without a response; all rK_readdatavalid=0, and rK_waitrequest=1 for any requester asserting read or write.

Structure
REQ-031 Package aib_axi_bridge_pkg holds the FSM state enum, the constant ERR_RDATA=32'hDEAD_BEEF and the default ADDR_W/DATA_W.
REQ-032 No sub-module; the arbiter is one module of 150-250 lines.

Verification
REQ-033 r0 writes 0x200=0x1234_5678, PHY waitrequest low after 3 cycles -> m_write seen 3 cycles with matching data, r0_waitrequest drops in the 3rd, grant returns to 0.
REQ-034 r0 and r1 read in the same cycle twice in sequence -> first grant 2'b01, second 2'b10; each requester gets only its own readdata.
REQ-035 r1 reads with PHY readdatavalid 5 cycles after the accept -> FSM sits in RDWAIT 5 cycles, r1_readdatavalid pulses once, r0 stays stalled.
REQ-036 PHY holds waitrequest high for 300 cycles, TIMEOUT_CYC=255 -> abort at cycle 255, r0 gets readdatavalid with 0xDEADBEEF, timeout_err=1 until clr_err.
REQ-037 avmm_rst_n asserted during RDWAIT -> next cycle grant=0, no readdatavalid, later PHY readdatavalid dropped.

Source files
------------

// File: rtl/aib_axi_bridge_pkg.sv
// Shared types and constants for the AIB PHY AVMM configuration arbiter.
// Holds the arbiter FSM encoding, default bus widths and the timeout read pattern.
package aib_axi_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMD    = 2'd1,
    ST_RDWAIT = 2'd2
  } arb_state_e;

  localparam int DEF_ADDR_W = 17;
  localparam int DEF_DATA_W = 32;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/aib_avmm_cfg_arbiter.sv
// Two-requester round-robin arbiter in front of the AIB PHY AVMM config port.
// One transfer at a time; a stuck PHY is abandoned after TIMEOUT_CYC cycles.
module aib_avmm_cfg_arbiter
  import aib_axi_bridge_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                avmm_clk,
  input  logic                avmm_rst_n,

  input  logic [ADDR_W-1:0]   r0_address,
  input  logic                r0_read,
  input  logic                r0_write,
  input  logic [DATA_W-1:0]   r0_writedata,
  input  logic [DATA_W/8-1:0] r0_byteenable,
  output logic [DATA_W-1:0]   r0_readdata,
  output logic                r0_readdatavalid,
  output logic                r0_waitrequest,

  input  logic [ADDR_W-1:0]   r1_address,
  input  logic                r1_read,
  input  logic                r1_write,
  input  logic [DATA_W-1:0]   r1_writedata,
  input  logic [DATA_W/8-1:0] r1_byteenable,
  output logic [DATA_W-1:0]   r1_readdata,
  output logic                r1_readdatavalid,
  output logic                r1_waitrequest,

  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  input  logic                m_waitrequest,

  input  logic                clr_err,
  output logic [1:0]          grant,
  output logic                timeout_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_RDATA);

  arb_state_e       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic              req0, req1, pick1, sel1;
  logic              sel_read, sel_write, sel_req;
  logic              timeout_hit, xfer_done;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic              gnt_wait, gnt_rdv;
  logic [DATA_W-1:0] gnt_rdata;

  // last_q=1 means r1 owned the port most recently, so r0 wins the next tie.
  always_comb begin
    req0        = r0_read | r0_write;
    req1        = r1_read | r1_write;
    pick1       = req1 & (~req0 | ~last_q);
    sel1        = grant_q[1];
    sel_addr    = sel1 ? r1_address    : r0_address;
    sel_wdata   = sel1 ? r1_writedata  : r0_writedata;
    sel_be      = sel1 ? r1_byteenable : r0_byteenable;
    sel_write   = sel1 ? r1_write      : r0_write;
    sel_read    = (sel1 ? r1_read : r0_read) & ~sel_write;
    sel_req     = sel_read | sel_write;
    timeout_hit = (state_q != ST_IDLE) && (cnt_q == CNT_MAX);
  end

  always_comb begin
    m_address    = sel_addr;
    m_writedata  = sel_wdata;
    m_byteenable = sel_be;
    m_write      = (state_q == ST_CMD) & sel_write & ~timeout_hit;
    m_read       = (state_q == ST_CMD) & sel_read  & ~timeout_hit;
  end

  // Response seen by the granted requester; everyone else is held off.
  always_comb begin
    gnt_wait  = sel_req;
    gnt_rdv   = 1'b0;
    gnt_rdata = '0;
    case (state_q)
      ST_CMD: begin
        gnt_wait = m_waitrequest;
        if (sel_read && !m_waitrequest) begin
          gnt_rdv   = m_readdatavalid;
          gnt_rdata = m_readdata;
        end
      end
      ST_RDWAIT: begin
        gnt_rdv   = m_readdatavalid;
        gnt_rdata = m_readdata;
      end
      default: ;
    endcase
    if (timeout_hit) begin
      gnt_wait  = 1'b0;
      gnt_rdv   = (state_q == ST_RDWAIT) | sel_read;
      gnt_rdata = gnt_rdv ? ERR_WORD : '0;
    end

    r0_waitrequest   = req0;
    r0_readdatavalid = 1'b0;
    r0_readdata      = '0;
    r1_waitrequest   = req1;
    r1_readdatavalid = 1'b0;
    r1_readdata      = '0;
    if (state_q != ST_IDLE) begin
      if (sel1) begin
        r1_waitrequest   = gnt_wait;
        r1_readdatavalid = gnt_rdv;
        r1_readdata      = gnt_rdata;
      end else begin
        r0_waitrequest   = gnt_wait;
        r0_readdatavalid = gnt_rdv;
        r0_readdata      = gnt_rdata;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q + CNT_W'(1);
    err_d     = err_q & ~clr_err;
    xfer_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req0 || req1) begin
          state_d = ST_CMD;
          grant_d = pick1 ? 2'b10 : 2'b01;
          last_d  = pick1;
        end
      end
      ST_CMD: begin
        if (!m_waitrequest) begin
          if (sel_write) begin
            xfer_done = 1'b1;
          end else if (sel_read) begin
            if (m_readdatavalid) xfer_done = 1'b1;
            else                 state_d   = ST_RDWAIT;
          end
        end
      end
      ST_RDWAIT: begin
        if (m_readdatavalid) xfer_done = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // A timeout wins over any late PHY handshake in the same cycle.
    if (timeout_hit) begin
      xfer_done = 1'b1;
      err_d     = 1'b1;
    end
    if (xfer_done) begin
      state_d = ST_IDLE;
      grant_d = '0;
    end
  end

  always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
    if (!avmm_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign grant       = grant_q;
  assign timeout_err = err_q;

endmodule
